// File: rtl/wca_cordic_pkg.sv
// Constants shared by the CORDIC datapath and the blocks that schedule work onto it.
package wca_cordic_pkg;

  localparam int CORDIC_BIT_WIDTH = 12;
  localparam int CORDIC_LATENCY   = 12;
  localparam int MODE_ROTATE      = 0;
  localparam int MODE_VECTOR      = 1;

  // Increment an index modulo n (n need not be a power of two).
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wca_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr_i.
module wca_rr_arbiter #(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic [NCH-1:0] req_i,
  input  logic [CHW-1:0] ptr_i,
  output logic [NCH-1:0] grant_o,
  output logic [CHW-1:0] grant_idx_o,
  output logic           grant_any_o
);

  int idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    idx         = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = (int'(ptr_i) + i) % NCH;
      if (!grant_any_o && req_i[idx]) begin
        grant_any_o  = 1'b1;
        grant_idx_o  = CHW'(idx);
        grant_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wca_cordic_sched.sv
// Round-robin scheduler sharing one pipelined CORDIC among NCH requesters; a tag pipe
// tracks the originating channel of each in-flight sample so results return to their owner.
module wca_cordic_sched
  import wca_cordic_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int CHW       = 2,
  parameter int BIT_WIDTH = CORDIC_BIT_WIDTH,
  parameter int LATENCY   = CORDIC_LATENCY
) (
  input  logic                     clock,
  input  logic                     ngreset,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NCH-1:0]           req_valid,
  input  logic [NCH*BIT_WIDTH-1:0] req_x,
  input  logic [NCH*BIT_WIDTH-1:0] req_y,
  input  logic [NCH*BIT_WIDTH-1:0] req_a,
  output logic [NCH-1:0]           req_ready,
  output logic                     cordic_strobe,
  output logic                     cordic_reset,
  output logic [BIT_WIDTH-1:0]     cordic_x0,
  output logic [BIT_WIDTH-1:0]     cordic_y0,
  output logic [BIT_WIDTH-1:0]     cordic_a0,
  input  logic [BIT_WIDTH-1:0]     cordic_xn,
  input  logic [BIT_WIDTH-1:0]     cordic_yn,
  input  logic [BIT_WIDTH-1:0]     cordic_an,
  output logic [NCH-1:0]           res_valid,
  output logic [CHW-1:0]           res_chan,
  output logic [BIT_WIDTH-1:0]     res_x,
  output logic [BIT_WIDTH-1:0]     res_y,
  output logic [BIT_WIDTH-1:0]     res_a,
  output logic                     busy
);

  logic [NCH-1:0]       req_mask;
  logic [NCH-1:0]       grant;
  logic [CHW-1:0]       grant_idx;
  logic                 grant_any;
  logic [CHW-1:0]       rr_q, rr_d;
  logic [BIT_WIDTH-1:0] op_x [NCH];
  logic [BIT_WIDTH-1:0] op_y [NCH];
  logic [BIT_WIDTH-1:0] op_a [NCH];
  logic [LATENCY-1:0]   tag_valid_q;
  logic [CHW-1:0]       tag_chan_q [LATENCY];
  logic                 strobe_q;
  logic                 capture;
  logic [NCH-1:0]       res_valid_q, res_valid_d;
  logic [CHW-1:0]       res_chan_q;
  logic [BIT_WIDTH-1:0] res_x_q, res_y_q, res_a_q;

  // Handshake: a request transfers when req_valid[i] & req_ready[i]; ready is the
  // combinational grant, so it may depend on valid, and it is forced low during sync reset.
  assign req_mask = req_valid & {NCH{enable & ~reset}};

  wca_rr_arbiter #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_arb (
    .req_i       (req_mask),
    .ptr_i       (rr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  assign req_ready    = grant;
  assign cordic_reset = reset;

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign op_x[i] = req_x[i*BIT_WIDTH +: BIT_WIDTH];
    assign op_y[i] = req_y[i*BIT_WIDTH +: BIT_WIDTH];
    assign op_a[i] = req_a[i*BIT_WIDTH +: BIT_WIDTH];
  end

  always_comb begin
    cordic_x0 = '0;
    cordic_y0 = '0;
    cordic_a0 = '0;
    if (grant_any) begin
      cordic_x0 = op_x[grant_idx];
      cordic_y0 = op_y[grant_idx];
      cordic_a0 = op_a[grant_idx];
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_any) rr_d = CHW'(wrap_inc(32'(grant_idx), NCH));
  end

  // A sample alone in the final stage needs no further strobe; it is captured from there.
  assign cordic_strobe = grant_any | (|tag_valid_q[LATENCY-2:0]);
  assign capture       = strobe_q & tag_valid_q[LATENCY-1];

  always_comb begin
    res_valid_d = '0;
    if (capture) res_valid_d[tag_chan_q[LATENCY-1]] = 1'b1;
  end

  always_ff @(posedge clock or negedge ngreset) begin
    if (!ngreset) begin
      rr_q        <= '0;
      strobe_q    <= 1'b0;
      tag_valid_q <= '0;
      for (int k = 0; k < LATENCY; k++) tag_chan_q[k] <= '0;
    end else if (reset) begin
      rr_q        <= '0;
      strobe_q    <= 1'b0;
      tag_valid_q <= '0;
      for (int k = 0; k < LATENCY; k++) tag_chan_q[k] <= '0;
    end else begin
      rr_q     <= rr_d;
      strobe_q <= cordic_strobe;
      if (cordic_strobe) begin
        tag_valid_q   <= {tag_valid_q[LATENCY-2:0], grant_any};
        tag_chan_q[0] <= grant_idx;
        for (int k = 1; k < LATENCY; k++) tag_chan_q[k] <= tag_chan_q[k-1];
      end else if (capture) begin
        // Retire the consumed final-stage tag so busy can fall while the pipe idles.
        tag_valid_q[LATENCY-1] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge ngreset) begin
    if (!ngreset) begin
      res_valid_q <= '0;
      res_chan_q  <= '0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      res_a_q     <= '0;
    end else if (reset) begin
      res_valid_q <= '0;
      res_chan_q  <= '0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      res_a_q     <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      if (capture) begin
        res_chan_q <= tag_chan_q[LATENCY-1];
        res_x_q    <= cordic_xn;
        res_y_q    <= cordic_yn;
        res_a_q    <= cordic_an;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_chan  = res_chan_q;
  assign res_x     = res_x_q;
  assign res_y     = res_y_q;
  assign res_a     = res_a_q;
  assign busy      = (|tag_valid_q) | (|res_valid_q);

endmodule

// File: tb/tb_wca_cordic_sched.sv
// Directed bench for wca_cordic_sched with a behavioural 12-stage rotation CORDIC attached.
module tb_wca_cordic_sched;

  localparam int W = 38;

  typedef struct {
    int          cyc;
    logic [3:0]  onehot;
    logic [1:0]  chan;
    logic [35:0] data;
  } res_t;

  logic        clk = 1'b0;
  logic        ngreset, reset, enable;
  logic [3:0]  req_valid, req_ready;
  logic [47:0] req_x, req_y, req_a;
  logic        cordic_strobe, cordic_reset;
  logic [11:0] cordic_x0, cordic_y0, cordic_a0;
  logic [11:0] cordic_xn, cordic_yn, cordic_an;
  logic [3:0]  res_valid;
  logic [1:0]  res_chan;
  logic [11:0] res_x, res_y, res_a;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc[$];
  res_t         obs_q[$];
  logic [35:0]  stg [12];

  wca_cordic_sched dut (
    .clock         (clk),
    .ngreset       (ngreset),
    .reset         (reset),
    .enable        (enable),
    .req_valid     (req_valid),
    .req_x         (req_x),
    .req_y         (req_y),
    .req_a         (req_a),
    .req_ready     (req_ready),
    .cordic_strobe (cordic_strobe),
    .cordic_reset  (cordic_reset),
    .cordic_x0     (cordic_x0),
    .cordic_y0     (cordic_y0),
    .cordic_a0     (cordic_a0),
    .cordic_xn     (cordic_xn),
    .cordic_yn     (cordic_yn),
    .cordic_an     (cordic_an),
    .res_valid     (res_valid),
    .res_chan      (res_chan),
    .res_x         (res_x),
    .res_y         (res_y),
    .res_a         (res_a),
    .busy          (busy)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- CORDIC model ----------------
  function automatic logic [11:0] atan_lut(input int i);
    case (i)
      0: return 12'd512;
      1: return 12'd302;
      2: return 12'd160;
      3: return 12'd81;
      4: return 12'd41;
      5: return 12'd20;
      6: return 12'd10;
      7: return 12'd5;
      8: return 12'd3;
      9: return 12'd1;
      10: return 12'd1;
      default: return 12'd0;
    endcase
  endfunction

  function automatic logic [35:0] cstep(input logic [11:0] x, input logic [11:0] y,
                                        input logic [11:0] a, input int i);
    logic signed [11:0] xs, ys, dx, dy;
    xs = x;
    ys = y;
    dx = ys >>> i;
    dy = xs >>> i;
    if (!a[11]) return {12'(xs - dx), 12'(ys + dy), 12'(a - atan_lut(i))};
    return {12'(xs + dx), 12'(ys - dy), 12'(a + atan_lut(i))};
  endfunction

  function automatic logic [35:0] golden(input logic [11:0] x, input logic [11:0] y,
                                         input logic [11:0] a);
    logic [35:0] s;
    s = {x, y, a};
    for (int i = 0; i < 12; i++) s = cstep(s[35:24], s[23:12], s[11:0], i);
    return s;
  endfunction

  always @(posedge clk or negedge ngreset) begin
    if (!ngreset || cordic_reset) begin
      for (int k = 0; k < 12; k++) stg[k] <= '0;
    end else if (cordic_strobe) begin
      stg[0] <= cstep(cordic_x0, cordic_y0, cordic_a0, 0);
      for (int k = 1; k < 12; k++) stg[k] <= cstep(stg[k-1][35:24], stg[k-1][23:12], stg[k-1][11:0], k);
    end
  end

  assign cordic_xn = stg[11][35:24];
  assign cordic_yn = stg[11][23:12];
  assign cordic_an = stg[11][11:0];

  // ---------------- result collector ----------------
  always @(negedge clk) begin
    res_t r;
    if (ngreset && res_valid != 4'b0000) begin
      r.cyc    = cyc;
      r.onehot = res_valid;
      r.chan   = res_chan;
      r.data   = {res_x, res_y, res_a};
      obs_q.push_back(r);
    end
  end

  // ---------------- stimulus patterns and drivers ----------------
  function automatic logic [11:0] pat_x(input int n, input int ch);
    return 12'(12'h0C0 + n * 8 + ch * 3);
  endfunction
  function automatic logic [11:0] pat_y(input int n, input int ch);
    return 12'(ch * 40 - n * 5);
  endfunction
  function automatic logic [11:0] pat_a(input int n, input int ch);
    return 12'(n * 97 + ch * 211 - 600);
  endfunction
  function automatic logic [W-1:0] exp_entry(input int n, input int ch);
    return {2'(ch), golden(pat_x(n, ch), pat_y(n, ch), pat_a(n, ch))};
  endfunction

  task automatic drive_cycle(input int n, input logic [3:0] v, output logic [3:0] g);
    @(negedge clk);
    for (int ch = 0; ch < 4; ch++) begin
      req_x[ch*12 +: 12] = pat_x(n, ch);
      req_y[ch*12 +: 12] = pat_y(n, ch);
      req_a[ch*12 +: 12] = pat_a(n, ch);
    end
    req_valid = v;
    #1;
    g = req_ready;
  endtask

  task automatic wait_results(input int n, input int budget, output bit ok);
    int i;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < budget) begin
      @(negedge clk);
      #1;
      if (obs_q.size() >= n) ok = 1'b1;
      i++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ngreset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_held: got %b expected 0", busy); end
    ngreset = 1'b1;
    @(negedge clk);
    #1;
    n_vec++; if (res_valid !== 4'b0000) begin n_err++; $display("FAIL reset_res_valid: got %b expected 0000", res_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (cordic_strobe !== 1'b0) begin n_err++; $display("FAIL reset_strobe: got %b expected 0", cordic_strobe); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    n_vec++; if (res_chan !== 2'd0) begin n_err++; $display("FAIL reset_res_chan: got %0d expected 0", res_chan); end
    n_vec++; if ({res_x, res_y, res_a} !== 36'h0) begin n_err++; $display("FAIL reset_res_data: got %h expected 0", {res_x, res_y, res_a}); end
    n_vec++; if (cordic_x0 !== 12'h000) begin n_err++; $display("FAIL reset_x0: got %h expected 000", cordic_x0); end
    n_vec++; if (cordic_reset !== 1'b0) begin n_err++; $display("FAIL reset_cordic_reset: got %b expected 0", cordic_reset); end
  endtask

  task automatic test_single();
    int k;
    logic [35:0] gold;
    obs_q.delete();
    gold = golden(12'h26D, 12'h000, 12'h200);
    @(negedge clk);
    req_x = '0; req_y = '0; req_a = '0;
    req_x[24 +: 12] = 12'h26D;
    req_a[24 +: 12] = 12'h200;
    req_valid = 4'b0100;
    #1;
    k = cyc;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    n_vec++; if ({cordic_x0, cordic_y0, cordic_a0} !== 36'h26D000200) begin n_err++; $display("FAIL single_operands: got %h expected 26d000200", {cordic_x0, cordic_y0, cordic_a0}); end
    n_vec++; if (cordic_strobe !== 1'b1) begin n_err++; $display("FAIL single_strobe_issue: got %b expected 1", cordic_strobe); end
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (j == 1) req_valid = 4'b0000;
      #1;
      n_vec++; if (cordic_strobe !== (j <= 11)) begin n_err++; $display("FAIL single_strobe[+%0d]: got %b expected %b", j, cordic_strobe, (j <= 11)); end
      n_vec++; if (res_valid !== ((j == 13) ? 4'b0100 : 4'b0000)) begin n_err++; $display("FAIL single_res_valid[+%0d]: got %b expected %b", j, res_valid, ((j == 13) ? 4'b0100 : 4'b0000)); end
      n_vec++; if (busy !== (j <= 13)) begin n_err++; $display("FAIL single_busy[+%0d]: got %b expected %b", j, busy, (j <= 13)); end
    end
    n_vec++;
    if (obs_q.size() != 1) begin
      n_err++; $display("FAIL single_count: got %0d results expected 1", obs_q.size());
    end else begin
      n_vec++; if (obs_q[0].chan !== 2'd2) begin n_err++; $display("FAIL single_chan: got %0d expected 2", obs_q[0].chan); end
      n_vec++; if (obs_q[0].data !== gold) begin n_err++; $display("FAIL single_data: got %h expected %h", obs_q[0].data, gold); end
      n_vec++; if (obs_q[0].cyc !== k + 13) begin n_err++; $display("FAIL single_latency: got cycle %0d expected %0d", obs_q[0].cyc, k + 13); end
    end
  endtask

  task automatic test_contention();
    logic [3:0] g;
    bit         ok;
    obs_q.delete(); exp_q.delete(); exp_cyc.delete();
    drive_cycle(0, 4'b1000, g);
    n_vec++; if (g !== 4'b1000) begin n_err++; $display("FAIL contention_preload: got %b expected 1000", g); end
    exp_q.push_back(exp_entry(0, 3)); exp_cyc.push_back(cyc);
    for (int n = 1; n <= 8; n++) begin
      drive_cycle(n, 4'b1111, g);
      n_vec++; if (g !== 4'(1 << ((n - 1) % 4))) begin n_err++; $display("FAIL contention_grant[%0d]: got %b expected %b", n, g, 4'(1 << ((n - 1) % 4))); end
      exp_q.push_back(exp_entry(n, (n - 1) % 4)); exp_cyc.push_back(cyc);
    end
    drive_cycle(0, 4'b0000, g);
    wait_results(9, 40, ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL contention_timeout: got %0d results expected 9", obs_q.size());
    end else begin
      for (int j = 0; j < 9; j++) begin
        n_vec++; if ({obs_q[j].chan, obs_q[j].data} !== exp_q[j]) begin n_err++; $display("FAIL contention_res[%0d]: got %h expected %h", j, {obs_q[j].chan, obs_q[j].data}, exp_q[j]); end
        n_vec++; if (obs_q[j].cyc !== exp_cyc[j] + 13) begin n_err++; $display("FAIL contention_cycle[%0d]: got %0d expected %0d", j, obs_q[j].cyc, exp_cyc[j] + 13); end
        n_vec++; if (obs_q[j].onehot !== 4'(1 << exp_q[j][37:36])) begin n_err++; $display("FAIL contention_onehot[%0d]: got %b expected %b", j, obs_q[j].onehot, 4'(1 << exp_q[j][37:36])); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] g;
    bit         ok;
    logic [3:0] vs [4];
    logic [3:0] gs [4];
    int         cs [4];
    vs = '{4'b0100, 4'b1001, 4'b1001, 4'b1001};
    gs = '{4'b0100, 4'b1000, 4'b0001, 4'b1000};
    cs = '{2, 3, 0, 3};
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(20 + i, vs[i], g);
      n_vec++; if (g !== gs[i]) begin n_err++; $display("FAIL wrap_grant[%0d]: got %b expected %b", i, g, gs[i]); end
      exp_q.push_back(exp_entry(20 + i, cs[i]));
    end
    drive_cycle(0, 4'b0000, g);
    wait_results(4, 30, ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL wrap_timeout: got %0d results expected 4", obs_q.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        n_vec++; if ({obs_q[j].chan, obs_q[j].data} !== exp_q[j]) begin n_err++; $display("FAIL wrap_res[%0d]: got %h expected %h", j, {obs_q[j].chan, obs_q[j].data}, exp_q[j]); end
      end
    end
  endtask

  task automatic test_enable_low();
    logic [3:0] g;
    int         last;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(30 + i, 4'b1111, g);
      n_vec++; if (g !== 4'(1 << i)) begin n_err++; $display("FAIL enable_grant[%0d]: got %b expected %b", i, g, 4'(1 << i)); end
      exp_q.push_back(exp_entry(30 + i, i));
    end
    last = cyc;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      enable = 1'b0;
      #1;
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL enable_ready[+%0d]: got %b expected 0000", j, req_ready); end
      n_vec++; if (cordic_strobe !== (j <= 11)) begin n_err++; $display("FAIL enable_strobe[+%0d]: got %b expected %b", j, cordic_strobe, (j <= 11)); end
    end
    n_vec++;
    if (obs_q.size() != 3) begin
      n_err++; $display("FAIL enable_count: got %0d results expected 3", obs_q.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        n_vec++; if ({obs_q[j].chan, obs_q[j].data} !== exp_q[j]) begin n_err++; $display("FAIL enable_res[%0d]: got %h expected %h", j, {obs_q[j].chan, obs_q[j].data}, exp_q[j]); end
      end
      n_vec++; if (obs_q[2].cyc !== last + 13) begin n_err++; $display("FAIL enable_last_cycle: got %0d expected %0d", obs_q[2].cyc, last + 13); end
    end
    @(negedge clk);
    req_valid = 4'b0000;
    enable    = 1'b1;
  endtask

  task automatic test_sync_reset();
    logic [3:0] g;
    bit         ok;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(40 + i, 4'b0111, g);
      n_vec++; if (g !== 4'(1 << (i % 3))) begin n_err++; $display("FAIL sreset_grant[%0d]: got %b expected %b", i, g, 4'(1 << (i % 3))); end
    end
    drive_cycle(0, 4'b0000, g);
    drive_cycle(0, 4'b0000, g);
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 4'b1111;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL sreset_ready: got %b expected 0000", req_ready); end
    n_vec++; if (cordic_reset !== 1'b1) begin n_err++; $display("FAIL sreset_cordic_reset_hi: got %b expected 1", cordic_reset); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL sreset_busy_before: got %b expected 1", busy); end
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 4'b0000;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sreset_busy: got %b expected 0", busy); end
    n_vec++; if (cordic_strobe !== 1'b0) begin n_err++; $display("FAIL sreset_strobe: got %b expected 0", cordic_strobe); end
    n_vec++; if (cordic_reset !== 1'b0) begin n_err++; $display("FAIL sreset_cordic_reset_lo: got %b expected 0", cordic_reset); end
    repeat (16) @(negedge clk);
    #1;
    n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL sreset_flushed: got %0d results expected 0", obs_q.size()); end
    drive_cycle(45, 4'b1010, g);
    n_vec++; if (g !== 4'b0010) begin n_err++; $display("FAIL sreset_pointer: got %b expected 0010", g); end
    exp_q.push_back(exp_entry(45, 1));
    drive_cycle(0, 4'b0000, g);
    wait_results(1, 30, ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL sreset_probe_timeout: got %0d results expected 1", obs_q.size());
    end else begin
      n_vec++; if ({obs_q[0].chan, obs_q[0].data} !== exp_q[0]) begin n_err++; $display("FAIL sreset_probe_res: got %h expected %h", {obs_q[0].chan, obs_q[0].data}, exp_q[0]); end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] g;
    bit         ok;
    int         i;
    obs_q.delete(); exp_q.delete();
    drive_cycle(50, 4'b0001, g);
    n_vec++; if (g !== 4'b0001) begin n_err++; $display("FAIL areset_grant0: got %b expected 0001", g); end
    drive_cycle(51, 4'b0010, g);
    n_vec++; if (g !== 4'b0010) begin n_err++; $display("FAIL areset_grant1: got %b expected 0010", g); end
    drive_cycle(0, 4'b0000, g);
    ok = 1'b0;
    i  = 0;
    while (!ok && i < 30) begin
      @(negedge clk);
      #1;
      if (res_valid !== 4'b0000) ok = 1'b1;
      i++;
    end
    n_vec++; if (!ok) begin n_err++; $display("FAIL areset_wait: got no result within 30 cycles expected one"); end
    #1;
    ngreset = 1'b0;
    #1;
    n_vec++; if (res_valid !== 4'b0000) begin n_err++; $display("FAIL areset_res_valid: got %b expected 0000", res_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL areset_busy: got %b expected 0", busy); end
    n_vec++; if (cordic_strobe !== 1'b0) begin n_err++; $display("FAIL areset_strobe: got %b expected 0", cordic_strobe); end
    n_vec++; if ({res_x, res_y, res_a} !== 36'h0) begin n_err++; $display("FAIL areset_res_data: got %h expected 0", {res_x, res_y, res_a}); end
    obs_q.delete();
    @(negedge clk);
    ngreset = 1'b1;
    repeat (16) @(negedge clk);
    #1;
    n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL areset_flushed: got %0d results expected 0", obs_q.size()); end
    drive_cycle(53, 4'b1010, g);
    n_vec++; if (g !== 4'b0010) begin n_err++; $display("FAIL areset_pointer: got %b expected 0010", g); end
    exp_q.push_back(exp_entry(53, 1));
    drive_cycle(0, 4'b0000, g);
    wait_results(1, 30, ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL areset_probe_timeout: got %0d results expected 1", obs_q.size());
    end else begin
      n_vec++; if ({obs_q[0].chan, obs_q[0].data} !== exp_q[0]) begin n_err++; $display("FAIL areset_probe_res: got %h expected %h", {obs_q[0].chan, obs_q[0].data}, exp_q[0]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    ngreset   = 1'b0;
    reset     = 1'b0;
    enable    = 1'b1;
    req_valid = 4'b0000;
    req_x     = '0;
    req_y     = '0;
    req_a     = '0;
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_enable_low();
    test_sync_reset();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
